// File: rtl/demux_pkg.sv
// Shared defaults and channel state encoding for the class-steered
// demultiplexer with per-channel backpressure.
package demux_pkg;

  localparam int DEF_DATA_W  = 12;
  localparam int DEF_CLASS_W = 2;
  localparam int DEF_CNT_W   = 8;

  localparam logic EMPTY = 1'b0;
  localparam logic HELD  = 1'b1;

  typedef enum logic {
    ST_EMPTY = EMPTY,
    ST_HELD  = HELD
  } chan_state_e;

endpackage

// File: rtl/demux_chan.sv
// One output channel: a single-word skid hold register in front of a
// registered output word and a one-cycle write strobe.
module demux_chan
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pause,
  output logic              o_held,
  output logic              o_push,
  output logic [DATA_W-1:0] o_data
);

  chan_state_e       r_state;
  chan_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] w_hold_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_push;
  logic              w_push_nxt;

  // State, hold word, output word and strobe registers.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= ST_EMPTY;
      r_hold  <= {DATA_W{1'b0}};
      r_data  <= {DATA_W{1'b0}};
      r_push  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_data  <= w_data_nxt;
      r_push  <= w_push_nxt;
    end
  end

  // A held word always drains before the channel can accept again,
  // which is what keeps per-channel ordering intact.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_data_nxt  = r_data;
    w_push_nxt  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (i_acc) begin
          if (i_pause) begin
            w_state_nxt = ST_HELD;
            w_hold_nxt  = i_data;
          end else begin
            w_push_nxt = 1'b1;
            w_data_nxt = i_data;
          end
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_HELD: begin
        if (!i_pause) begin
          w_state_nxt = ST_EMPTY;
          w_push_nxt  = 1'b1;
          w_data_nxt  = r_hold;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  assign o_held = (r_state == ST_HELD);
  assign o_push = r_push;
  assign o_data = r_data;

endmodule

// File: rtl/demux_bp.sv
// Class-steered demultiplexer: routes each input word to one of N_CH
// channels, either stalling the source or dropping when that channel is full.
module demux_bp
  import demux_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int CLASS_W   = DEF_CLASS_W,
  parameter  int DROP_MODE = 0,
  parameter  int CNT_W     = DEF_CNT_W,
  localparam int N_CH      = 2 ** CLASS_W
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   valid_in,
  input  logic [CLASS_W-1:0]     class_in,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [N_CH-1:0]        pause,
  output logic                   ready_in,
  output logic [N_CH*DATA_W-1:0] data_out,
  output logic [N_CH-1:0]        push,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_CH-1:0]  w_held;
  logic [N_CH-1:0]  w_sel;
  logic             w_cls_held;
  logic             w_acc;
  logic             w_drop;
  logic [CNT_W-1:0] r_drop_cnt;

  assign w_cls_held = w_held[class_in];
  assign w_acc      = valid_in & ~w_cls_held;
  assign w_drop     = (DROP_MODE != 0) & valid_in & w_cls_held;
  assign ready_in   = (DROP_MODE != 0) ? 1'b1 : ~w_cls_held;

  // One-hot steering of an accepted word to its channel.
  always_comb begin
    w_sel = {N_CH{1'b0}};
    if (w_acc) begin
      w_sel[class_in] = 1'b1;
    end else begin
      w_sel = {N_CH{1'b0}};
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    demux_chan #(
      .DATA_W(DATA_W)
    ) u_chan (
      .clk    (clk),
      .reset_L(reset_L),
      .i_acc  (w_sel[g]),
      .i_data (data_in),
      .i_pause(pause[g]),
      .o_held (w_held[g]),
      .o_push (push[g]),
      .o_data (data_out[g*DATA_W +: DATA_W])
    );
  end

  // Saturating count of words discarded because their channel was full.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_drop_cnt <= {CNT_W{1'b0}};
    end else if (w_drop && (r_drop_cnt != CNT_MAX)) begin
      r_drop_cnt <= r_drop_cnt + CNT_ONE;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_bp.sv
// Scoreboard bench: a stall-mode instance and a drop-mode instance with a
// 2-bit drop counter, both checked against a queue-based reference model.
module tb_demux_bp;

  localparam int DW = 12;
  localparam int NC = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             vin  [2];
  logic [1:0]       cls  [2];
  logic [DW-1:0]    din  [2];
  logic [NC-1:0]    pz   [2];
  logic             rdy  [2];
  logic [NC*DW-1:0] dout [2];
  logic [NC-1:0]    psh  [2];
  logic [7:0]       dcnt0;
  logic [1:0]       dcnt1;

  demux_bp #(.DATA_W(DW), .CLASS_W(2), .DROP_MODE(0), .CNT_W(8)) u_stall (
    .clk(clk), .reset_L(rst_n), .valid_in(vin[0]), .class_in(cls[0]), .data_in(din[0]),
    .pause(pz[0]), .ready_in(rdy[0]), .data_out(dout[0]), .push(psh[0]), .drop_cnt(dcnt0));

  demux_bp #(.DATA_W(DW), .CLASS_W(2), .DROP_MODE(1), .CNT_W(2)) u_drop (
    .clk(clk), .reset_L(rst_n), .valid_in(vin[1]), .class_in(cls[1]), .data_in(din[1]),
    .pause(pz[1]), .ready_in(rdy[1]), .data_out(dout[1]), .push(psh[1]), .drop_cnt(dcnt1));

  // Reference model: which channels hold a word, expected deliveries, drops.
  int            mode     [2] = '{0, 1};
  int            drop_max [2] = '{255, 3};
  bit            held     [2][NC];
  logic [DW-1:0] hword    [2][NC];
  logic [DW-1:0] last     [2][NC];
  exp_t          q        [2][NC][$];
  int            drop_cur [2];
  int            drop_nxt [2];
  int            cyc;
  bit            mon_en;
  int            total;
  int            bad;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input int k, input int c, input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    q[k][c].push_back(e);
  endtask

  task automatic model_cycle(input int k);
    bit hp[NC];
    for (int c = 0; c < NC; c++) hp[c] = held[k][c];
    for (int c = 0; c < NC; c++) begin
      if (hp[c]) begin
        if (!pz[k][c]) begin
          push_exp(k, c, hword[k][c]);
          held[k][c] = 1'b0;
        end
      end else if (vin[k] && (int'(cls[k]) == c)) begin
        if (!pz[k][c]) push_exp(k, c, din[k]);
        else begin
          held[k][c]  = 1'b1;
          hword[k][c] = din[k];
        end
      end
    end
    drop_nxt[k] = drop_cur[k];
    if ((mode[k] != 0) && vin[k] && hp[cls[k]])
      drop_nxt[k] = (drop_cur[k] < drop_max[k]) ? drop_cur[k] + 1 : drop_cur[k];
  endtask

  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready_in[%0d]", k), int'(rdy[k]),
          (mode[k] != 0) ? 1 : int'(!held[k][cls[k]]));
      model_cycle(k);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) drop_cur[k] = drop_nxt[k];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) vin[k] = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NC; c++) begin
        held[k][c] = 1'b0;
        last[k][c] = '0;
        q[k][c].delete();
      end
      drop_cur[k] = 0;
      drop_nxt[k] = 0;
    end
    mon_en = 1'b1;
    rst_n  = 1'b1;
  endtask

  task automatic send(input int k, input int c, input int d);
    vin[k] = 1'b1;
    cls[k] = 2'(c);
    din[k] = DW'(d);
  endtask

  // Monitor: every strobe must match the head of its channel queue in
  // cycle and data; idle channels must keep their last delivered word.
  always @(negedge clk) begin
    logic [DW-1:0] d;
    bit            e;
    exp_t          x;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < NC; c++) begin
          d = dout[k][c*DW +: DW];
          e = (q[k][c].size() > 0) && (q[k][c][0].cyc == cyc);
          chk($sformatf("push[%0d][%0d]", k, c), int'(psh[k][c]), int'(e));
          if (e) begin
            x = q[k][c].pop_front();
            if (psh[k][c]) begin
              chk($sformatf("data[%0d][%0d]", k, c), int'(d), int'(x.data));
              last[k][c] = x.data;
            end
          end else begin
            chk($sformatf("hold_out[%0d][%0d]", k, c), int'(d), int'(last[k][c]));
          end
        end
        chk($sformatf("drop_cnt[%0d]", k), (k == 0) ? int'(dcnt0) : int'(dcnt1), drop_cur[k]);
      end
    end
  end

  initial begin
    total  = 0;
    bad    = 0;
    cyc    = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vin[k] = 1'b0;
      cls[k] = 2'd0;
      din[k] = '0;
      pz[k]  = 4'b0000;
    end
    do_reset();
    step();

    // In-order words to every class, no backpressure.
    for (int i = 0; i < 4; i++) begin
      send(0, i, i + 1);
      send(1, i, i + 1);
      step();
    end
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    step();
    step();

    // Stall mode: paused channel 1 holds 0x0A5 and deasserts ready.
    pz[0] = 4'b0010;
    send(0, 1, 'h0A5);
    step();
    vin[0] = 1'b0;
    step();
    step();
    pz[0] = 4'b0000;
    step();
    step();

    // Drop mode: one held word, five drops saturating a 2-bit counter.
    pz[1] = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      send(1, 2, 'h200 + i);
      step();
    end
    vin[1] = 1'b0;
    step();
    pz[1] = 4'b0000;
    step();
    step();

    // Paused channel 0 must not block classes 1 and 2.
    pz[0] = 4'b0001;
    send(0, 0, 'h111);
    step();
    send(0, 1, 'h222);
    step();
    send(0, 2, 'h333);
    step();
    vin[0] = 1'b0;
    step();
    pz[0] = 4'b0000;
    step();
    step();

    // Reset discards a held word; traffic resumes normally afterwards.
    pz[0] = 4'b1000;
    pz[1] = 4'b1000;
    send(0, 3, 'h123);
    send(1, 3, 'h123);
    step();
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    step();
    do_reset();
    pz[0] = 4'b0000;
    pz[1] = 4'b0000;
    step();
    step();
    send(0, 3, 'h456);
    send(1, 3, 'h456);
    step();
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    step();
    step();

    // Randomized traffic with random backpressure and one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        vin[k] = ($urandom_range(0, 3) != 0);
        cls[k] = 2'($urandom);
        din[k] = DW'($urandom);
        if ($urandom_range(0, 3) == 0) pz[k] = 4'($urandom & $urandom);
      end
      if (i == 300) do_reset();
      else step();
    end

    for (int k = 0; k < 2; k++) begin
      vin[k] = 1'b0;
      pz[k]  = 4'b0000;
    end
    for (int i = 0; i < 4; i++) step();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NC; c++)
        chk($sformatf("drained[%0d][%0d]", k, c), q[k][c].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
